rtype_exec_unit: RTL and testbench
==================================

RTYPE_EXEC_UNIT -- requirements
Module: rtype_exec_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and reset.
REQ-002 Parameter XLEN SHALL default to 32 and give the operand/result width; legal values are 32 and 64.
REQ-003 Derived localparam SHAMT_W SHALL equal $clog2(XLEN).
REQ-004 Port: clk, input, 1, rising-edge clock.
REQ-005 Port: reset, input, 1, asynchronous active-low reset.
REQ-006 Port: in_valid, input, 1, request present.
REQ-007 Port: in_ready, output, 1, request accepted when in_valid && in_ready at a clk edge.
REQ-008 Port: funct7, input, 7, R-type funct7 field.
REQ-009 Port: funct3, input, 3, R-type funct3 field.
REQ-010 Port: rv1, input, XLEN, source operand 1.
REQ-011 Port: rv2, input, XLEN, source operand 2.
REQ-012 Port: rd_addr, input, 5, destination tag, returned unchanged.
REQ-013 Port: out_valid, output, 1, result present.
REQ-014 Port: out_ready, input, 1, consumer takes result when out_valid && out_ready.
REQ-015 Port: out_data, output, XLEN, result.
REQ-016 Port: out_rd, output, 5, tag of the result.
REQ-017 Port: out_illegal, output, 1, funct7/funct3 pair not supported.
REQ-018 Port: busy, output, 1, high while state is CALC.

Function
REQ-019 FSM states SHALL be IDLE, CALC and HOLD; the reset state is IDLE.
REQ-020 in_ready SHALL be high in IDLE, and in HOLD when out_ready is high; it SHALL be low in CALC.
REQ-021 Base ops (funct7 0000000/0100000: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND) SHALL register their result at acceptance: out_valid high the next cycle, state IDLE/HOLD -> HOLD.
REQ-022 Shifts SHALL use rv2[SHAMT_W-1:0] only; SRA SHALL sign-fill; SLT SHALL compare signed and SLTU unsigned, giving result 0 or 1.
REQ-023 Add and subtract SHALL wrap modulo 2^XLEN, with no overflow flag.
REQ-024 An unsupported funct pair SHALL complete as a base op: out_data 0, out_illegal 1.
REQ-025 In HOLD, out_valid, out_data, out_rd and out_illegal SHALL stay stable until out_ready is high.
REQ-026 A handshake in HOLD with no new request SHALL move the FSM to IDLE and drop out_valid.
REQ-027 A simultaneous output and input handshake in HOLD SHALL accept the new request in that cycle, giving back-to-back throughput of one base op per cycle.
REQ-028 out_illegal SHALL be 0 for every legal op.

Reset
REQ-029 While reset is low, the FSM SHALL be IDLE, and out_valid, out_data, out_rd, out_illegal, busy and all iteration counters SHALL be 0.
REQ-030 Reset asserted during CALC or HOLD SHALL discard the operation with no result produced; in_ready SHALL be high in the first cycle after reset deasserts.

Configuration
REQ-031 Macro RV_MULDIV_EXT_EN defined: funct7 0000001 SHALL execute MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU iteratively.
REQ-032 With the macro, M-ops SHALL go to CALC for exactly XLEN cycles, then HOLD; out_valid SHALL rise XLEN+1 cycles after the accepting edge.
REQ-033 With the macro, divide-by-zero SHALL give quotient all-ones and remainder rv1; DIV of the most negative value by -1 SHALL give quotient = rv1 and remainder 0; both cases SHALL keep the full latency.
REQ-034 Without the macro, funct7 0000001 SHALL be illegal per REQ-024, the CALC state SHALL not be built, and busy SHALL be tied to 0.

Verification
REQ-035 XLEN=32, ADD with rv1=415, rv2=60, out_ready=1 -> out_valid one cycle later, out_data=475, out_illegal=0.
REQ-036 SRA with rv1=0x80000000, rv2=0x24 -> out_data=0xF8000000 (shift 4); SLT with -1 vs 1 -> 1; SLTU with the same operands -> 0.
REQ-037 Five back-to-back SUB requests, out_ready held 0 for 3 cycles then 1 -> first result stable through the stall; then one result per cycle, tags in order.
REQ-038 With the macro, DIV rv1=0x80000000, rv2=0xFFFFFFFF -> out_data=0x80000000 after 33 cycles, busy high for 32 cycles; DIVU by 0 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-039 Without the macro, MUL request -> out_data=0, out_illegal=1 one cycle later.
REQ-040 reset driven low at cycle 10 of a DIV -> outputs 0 immediately, no out_valid after release, in_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/rtype_exec_unit_if.sv
// Request/response bundle for rtype_exec_unit.
// The slave modport is the execution unit. The master modport is the requester and result consumer.
interface rtype_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rv1;
    logic [XLEN-1:0] rv2;
    logic [4:0]      rd_addr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [4:0]      out_rd;
    logic            out_illegal;
    logic            busy;

    modport master (
        output in_valid, funct7, funct3, rv1, rv2, rd_addr, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_illegal, busy
    );

    modport slave (
        input  in_valid, funct7, funct3, rv1, rv2, rd_addr, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_illegal, busy
    );
endinterface

// File: rtl/rtype_exec_unit.sv
// RV R-type execution unit: single-cycle base ALU ops with a registered, back-pressured result.
// Defining RV_MULDIV_EXT_EN adds iterative M-extension ops (XLEN-cycle shift-add / restoring divide).
module rtype_exec_unit #(
    parameter int XLEN = 32
) (
    input logic              clk,
    input logic              reset,
    rtype_exec_unit_if.slave bus
);
    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef RV_MULDIV_EXT_EN
        CALC = 2'd1,
`endif
        HOLD = 2'd2
    } state_t;

    state_t                 state;
    logic                   vld_p1;
    logic        [XLEN-1:0] data_p1;
    logic        [4:0]      rd_p1;
    logic                   illegal_p1;
    logic                   in_ready;
    logic                   accept;
    logic        [XLEN-1:0] base_res;
    logic                   base_legal;
    logic signed [XLEN-1:0] rv1_s;
    logic signed [XLEN-1:0] rv2_s;
    logic [SHAMT_W-1:0]     shamt;

    assign in_ready = (state == IDLE) || ((state == HOLD) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign rv1_s    = bus.rv1;
    assign rv2_s    = bus.rv2;
    assign shamt    = bus.rv2[SHAMT_W-1:0];

    always_comb begin
        base_legal = 1'b1;
        base_res   = '0;
        case ({bus.funct7, bus.funct3})
            {7'b0000000, 3'b000}: base_res = bus.rv1 + bus.rv2;
            {7'b0100000, 3'b000}: base_res = bus.rv1 - bus.rv2;
            {7'b0000000, 3'b001}: base_res = bus.rv1 << shamt;
            {7'b0000000, 3'b010}: base_res = {{(XLEN-1){1'b0}}, rv1_s < rv2_s};
            {7'b0000000, 3'b011}: base_res = {{(XLEN-1){1'b0}}, bus.rv1 < bus.rv2};
            {7'b0000000, 3'b100}: base_res = bus.rv1 ^ bus.rv2;
            {7'b0000000, 3'b101}: base_res = bus.rv1 >> shamt;
            {7'b0100000, 3'b101}: base_res = rv1_s >>> shamt;
            {7'b0000000, 3'b110}: base_res = bus.rv1 | bus.rv2;
            {7'b0000000, 3'b111}: base_res = bus.rv1 & bus.rv2;
            default:              base_legal = 1'b0;
        endcase
    end

`ifdef RV_MULDIV_EXT_EN
    logic                is_mop;
    logic [SHAMT_W-1:0]  cnt;
    logic [2:0]          m_f3;
    logic [XLEN-1:0]     hi;
    logic [XLEN-1:0]     lo;
    logic [XLEN-1:0]     opnd;
    logic [XLEN-1:0]     rv1_keep;
    logic                neg_q;
    logic                neg_r;
    logic                div_zero;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_sh;
    logic [XLEN:0]       div_diff;
    logic [XLEN-1:0]     step_hi;
    logic [XLEN-1:0]     step_lo;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     m_res;

    assign is_mop = (bus.funct7 == 7'b0000001);
    // Signedness per funct3: MULH/MULHSU/DIV/REM take rv1 signed; MULH/DIV/REM take rv2 signed.
    assign a_neg  = bus.rv1[XLEN-1] && (bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
    assign b_neg  = bus.rv2[XLEN-1] && (bus.funct3 inside {3'b001, 3'b100, 3'b110});
    assign a_mag  = a_neg ? -bus.rv1 : bus.rv1;
    assign b_mag  = b_neg ? -bus.rv2 : bus.rv2;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        div_sh   = {hi, lo[XLEN-1]};
        div_diff = div_sh - {1'b0, opnd};
        if (m_f3[2]) begin
            if (!div_diff[XLEN]) begin
                step_hi = div_diff[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_sh[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Sign fix-up and divide-by-zero override applied to the last iteration's value.
    always_comb begin
        prod_s = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        m_res  = '0;
        case (m_f3)
            3'b000:                 m_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: m_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         m_res = div_zero ? '1 : (neg_q ? -step_lo : step_lo);
            default:                m_res = div_zero ? rv1_keep : (neg_r ? -step_hi : step_hi);
        endcase
    end

    // p0: operand capture at acceptance, one iteration per CALC cycle
    always_ff @(posedge clk) begin
        if (accept && is_mop) begin
            m_f3     <= bus.funct3;
            rv1_keep <= bus.rv1;
            hi       <= '0;
            lo       <= bus.funct3[2] ? a_mag : b_mag;
            opnd     <= bus.funct3[2] ? b_mag : a_mag;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (bus.rv2 == '0);
        end else if (state == CALC) begin
            hi <= step_hi;
            lo <= step_lo;
        end
    end

    assign bus.busy = (state == CALC);
`else
    assign bus.busy = 1'b0;
`endif

    // p1: result register and control FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            rd_p1      <= '0;
            illegal_p1 <= 1'b0;
`ifdef RV_MULDIV_EXT_EN
            cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        rd_p1 <= bus.rd_addr;
`ifdef RV_MULDIV_EXT_EN
                        if (is_mop) begin
                            state  <= CALC;
                            vld_p1 <= 1'b0;
                            cnt    <= '0;
                        end else
`endif
                        begin
                            state      <= HOLD;
                            vld_p1     <= 1'b1;
                            data_p1    <= base_legal ? base_res : '0;
                            illegal_p1 <= !base_legal;
                        end
                    end else if ((state == HOLD) && bus.out_ready) begin
                        state  <= IDLE;
                        vld_p1 <= 1'b0;
                    end
                end
`ifdef RV_MULDIV_EXT_EN
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SHAMT_W'(XLEN-1)) begin
                        state      <= HOLD;
                        vld_p1     <= 1'b1;
                        data_p1    <= m_res;
                        illegal_p1 <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = vld_p1;
    assign bus.out_data    = data_p1;
    assign bus.out_rd      = rd_p1;
    assign bus.out_illegal = illegal_p1;
endmodule

// File: tb/tb_rtype_exec_unit.sv
// Directed bench for rtype_exec_unit (XLEN=32): base ALU table, stall/back-to-back, reset abort,
// and M-extension ops when RV_MULDIV_EXT_EN is defined.
module tb_rtype_exec_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    rtype_exec_unit_if #(.XLEN(32)) bus ();

    rtype_exec_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.in_valid = 1'b1;
        bus.funct7   = f7;
        bus.funct3   = f3;
        bus.rv1      = a;
        bus.rv2      = b;
        bus.rd_addr  = rd;
    endtask

    // Issue a base op at a negedge and check the result one cycle later.
    task automatic send_base(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                             input logic [31:0] exp, input logic ill);
        drive(f7, f3, a, b, rd);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        check({tag, "_data"}, {32'd0, bus.out_data}, {32'd0, exp});
        check({tag, "_illegal"}, {63'd0, bus.out_illegal}, {63'd0, ill});
        check({tag, "_rd"}, {59'd0, bus.out_rd}, {59'd0, rd});
    endtask

`ifdef RV_MULDIV_EXT_EN
    task automatic send_mop(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        int busy_cyc;
        drive(7'b0000001, f3, a, b, 5'd9);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        busy_cyc = 0;
        while (!bus.out_valid && n < 100) begin
            if (bus.busy) busy_cyc++;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd32);
        check({tag, "_data"}, {32'd0, bus.out_data}, {32'd0, exp});
        check({tag, "_illegal"}, {63'd0, bus.out_illegal}, 64'd0);
    endtask
`endif

    typedef struct packed {
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    vec_t vecs [12] = '{
        '{7'b0000000, 3'b000, 32'd415,        32'd60,         32'd475,        1'b0},
        '{7'b0100000, 3'b000, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0},
        '{7'b0000000, 3'b000, 32'hFFFF_FFFF,  32'd2,          32'd1,          1'b0},
        '{7'b0000000, 3'b001, 32'd3,          32'h21,         32'd6,          1'b0},
        '{7'b0000000, 3'b010, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0},
        '{7'b0000000, 3'b011, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0},
        '{7'b0000000, 3'b100, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1'b0},
        '{7'b0000000, 3'b101, 32'h8000_0000,  32'h24,         32'h0800_0000,  1'b0},
        '{7'b0100000, 3'b101, 32'h8000_0000,  32'h24,         32'hF800_0000,  1'b0},
        '{7'b0000000, 3'b110, 32'hF0F0_0000,  32'h0000_000F,  32'hF0F0_000F,  1'b0},
        '{7'b0000000, 3'b111, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0},
        '{7'b0100000, 3'b001, 32'd5,          32'd6,          32'd0,          1'b1}
    };

    logic [31:0] sub_exp [5] = '{32'd100, 32'd107, 32'd114, 32'd121, 32'd128};

    initial begin
        int idx;
        int got;
        int cyc;
        int seen;
        logic acc_in;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.funct7    = '0;
        bus.funct3    = '0;
        bus.rv1       = '0;
        bus.rv2       = '0;
        bus.rd_addr   = '0;
        bus.out_ready = 1'b1;

        #1;
        check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_data", {32'd0, bus.out_data}, 64'd0);
        check("rst_rd", {59'd0, bus.out_rd}, 64'd0);
        check("rst_illegal", {63'd0, bus.out_illegal}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);

        for (int i = 0; i < 12; i++)
            send_base($sformatf("vec%0d", i), vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b,
                      5'(i + 1), vecs[i].exp, vecs[i].ill);
        @(negedge clk);
        check("drain_valid", {63'd0, bus.out_valid}, 64'd0);

`ifndef RV_MULDIV_EXT_EN
        send_base("mul_nomacro", 7'b0000001, 3'b000, 32'd3, 32'd5, 5'd20, 32'd0, 1'b1);
        check("mul_nomacro_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
`endif

        // Five back-to-back SUBs with the consumer stalled for the first four cycles.
        idx = 0;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 50) begin
            bus.out_ready = (cyc >= 4);
            if (idx < 5) drive(7'b0100000, 3'b000, 32'(100 + 10 * idx), 32'(3 * idx), 5'(idx + 1));
            else bus.in_valid = 1'b0;
            #1;
            acc_in = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                check($sformatf("b2b_data_c%0d", cyc), {32'd0, bus.out_data}, {32'd0, sub_exp[got]});
                check($sformatf("b2b_rd_c%0d", cyc), {59'd0, bus.out_rd}, 64'(got + 1));
                if (bus.out_ready) got++;
            end
            if (acc_in) idx++;
            cyc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("b2b_cycles", 64'(cyc), 64'd9);
        check("b2b_drain_valid", {63'd0, bus.out_valid}, 64'd0);

`ifdef RV_MULDIV_EXT_EN
        send_mop("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        send_mop("divu_zero", 3'b101, 32'd1234, 32'd0, 32'hFFFF_FFFF);
        send_mop("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        send_mop("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
        send_mop("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        send_mop("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        send_mop("rem_zero", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        @(negedge clk);
        // Abort a DIV ten cycles into CALC.
        drive(7'b0000001, 3'b100, 32'd1000, 32'd7, 5'd3);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", {63'd0, bus.busy}, 64'd1);
`else
        // Abort a held result.
        bus.out_ready = 1'b0;
        drive(7'b0000000, 3'b000, 32'd415, 32'd60, 5'd3);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("abort_hold_valid", {63'd0, bus.out_valid}, 64'd1);
`endif
        reset = 1'b0;
        #1;
        check("abort_valid", {63'd0, bus.out_valid}, 64'd0);
        check("abort_data", {32'd0, bus.out_data}, 64'd0);
        check("abort_rd", {59'd0, bus.out_rd}, 64'd0);
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) seen++;
            @(negedge clk);
        end
        check("post_rst_no_valid", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
